// File: rtl/count_dir_decoder.sv
// Receive-side monitor for an up/down counter bus: classifies each sample-to-sample
// transition, recovers direction, locks on steady motion and counts illegal jumps.
// Define CNT_DIR_DECODER_WRAP_EN to accept the max->0 and 0->max wrap transitions as steps.
module count_dir_decoder #(
  parameter int WIDTH    = 3,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  output logic             dir,
  output logic             step_valid,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [3:0]       LOCK_RUN = 4'(LOCK_CNT);

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [3:0]       run;

  logic [WIDTH-1:0] prev_inc;
  logic [WIDTH-1:0] prev_dec;
  logic             wrap_up;
  logic             wrap_down;
  logic             is_up;
  logic             is_down;
  logic             is_hold;
  logic             is_step;
  logic [3:0]       run_next;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    prev_inc  = prev + ONE;
    prev_dec  = prev - ONE;
`ifdef CNT_DIR_DECODER_WRAP_EN
    wrap_up   = 1'b0;
    wrap_down = 1'b0;
`else
    wrap_up   = (prev == MAX_VAL) && (count_in == '0);
    wrap_down = (prev == '0) && (count_in == MAX_VAL);
`endif
    is_up    = (count_in == prev_inc) && !wrap_up;
    is_down  = (count_in == prev_dec) && !wrap_down;
    is_hold  = (count_in == prev);
    is_step  = is_up || is_down;
    // A first step or a step in the held direction extends the run; a reversal restarts it.
    run_next = ((run == 4'd0) || (is_down == dir)) ? run + 4'd1 : 4'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= '0;
      run        <= 4'd0;
      dir        <= 1'b0;
      step_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      step_valid <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          prev  <= count_in;
          run   <= 4'd0;
          state <= ACQ;
        end
        ACQ: begin
          prev <= count_in;
          if (is_step) begin
            step_valid <= 1'b1;
            dir        <= is_down;
            run        <= run_next;
            if (run_next >= LOCK_RUN) begin
              state  <= LOCK;
              locked <= 1'b1;
            end
          end else if (!is_hold) begin
            err <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            run <= 4'd0;
          end
        end
        LOCK: begin
          prev <= count_in;
          if (is_step) begin
            step_valid <= 1'b1;
            if (is_down != dir) begin
              dir    <= is_down;
              run    <= 4'd1;
              state  <= ACQ;
              locked <= 1'b0;
            end
          end else if (!is_hold) begin
            err <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            run    <= 4'd0;
            state  <= ACQ;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_dir_decoder.sv
// Directed self-checking bench for count_dir_decoder (WIDTH=3, LOCK_CNT=4).
// Wrap-step expectations follow CNT_DIR_DECODER_WRAP_EN as the RTL is built.
module tb_count_dir_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] count_in = 3'd0;
  logic       dir;
  logic       step_valid;
  logic       locked;
  logic       err;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  count_dir_decoder #(.WIDTH(3), .LOCK_CNT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .dir        (dir),
    .step_valid (step_valid),
    .locked     (locked),
    .err        (err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a sample, clock it in, then settle past the edge before checking.
  task automatic tick(input logic [2:0] v);
    count_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3'd0);
    tick(3'd0);
    reset = 1'b0;
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_dir"},       32'(dir),        32'd0);
    check({tag, "_step"},      32'(step_valid), 32'd0);
    check({tag, "_locked"},    32'(locked),     32'd0);
    check({tag, "_err"},       32'(err),        32'd0);
    check({tag, "_err_count"}, 32'(err_count),  32'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check_quiet_outputs("rst");

    // Count up 0..4: steps on edges 2-5, lock after edge 5
    tick(3'd0);
    check("up_idle_step", 32'(step_valid), 32'd0);
    for (int v = 1; v <= 3; v++) begin
      tick(3'(v));
      check("up_step", 32'(step_valid), 32'd1);
      check("up_dir", 32'(dir), 32'd0);
      check("up_not_locked", 32'(locked), 32'd0);
      check("up_no_err", 32'(err), 32'd0);
    end
    tick(3'd4);
    check("up4_step", 32'(step_valid), 32'd1);
    check("up4_locked", 32'(locked), 32'd1);
    check("up4_no_err", 32'(err), 32'd0);

    // Reversal 4->3 unlocks; three further down steps relock
    tick(3'd3);
    check("rev_step", 32'(step_valid), 32'd1);
    check("rev_dir", 32'(dir), 32'd1);
    check("rev_unlocked", 32'(locked), 32'd0);
    check("rev_run", 32'(dut.run), 32'd1);
    tick(3'd2);
    check("dn2_locked", 32'(locked), 32'd0);
    tick(3'd1);
    check("dn1_locked", 32'(locked), 32'd0);
    check("dn1_run", 32'(dut.run), 32'd3);
    tick(3'd0);
    check("dn0_step", 32'(step_valid), 32'd1);
    check("dn0_dir", 32'(dir), 32'd1);
    check("dn0_locked", 32'(locked), 32'd1);

    // Wrap transitions 6,7,0,1 then 0,7
    do_reset();
    tick(3'd6);
    tick(3'd7);
    check("w67_step", 32'(step_valid), 32'd1);
    check("w67_run", 32'(dut.run), 32'd1);
    tick(3'd0);
`ifdef CNT_DIR_DECODER_WRAP_EN
    check("w70_step", 32'(step_valid), 32'd1);
    check("w70_err", 32'(err), 32'd0);
    check("w70_err_count", 32'(err_count), 32'd0);
    check("w70_run", 32'(dut.run), 32'd2);
`else
    check("w70_step", 32'(step_valid), 32'd0);
    check("w70_err", 32'(err), 32'd1);
    check("w70_err_count", 32'(err_count), 32'd1);
    check("w70_run", 32'(dut.run), 32'd0);
`endif
    tick(3'd1);
    check("w01_step", 32'(step_valid), 32'd1);
    check("w01_err", 32'(err), 32'd0);
`ifdef CNT_DIR_DECODER_WRAP_EN
    check("w01_run", 32'(dut.run), 32'd3);
`else
    check("w01_run", 32'(dut.run), 32'd1);
`endif
    tick(3'd0);
    check("w10_dir", 32'(dir), 32'd1);
    check("w10_run", 32'(dut.run), 32'd1);
    tick(3'd7);
`ifdef CNT_DIR_DECODER_WRAP_EN
    check("w07_step", 32'(step_valid), 32'd1);
    check("w07_err", 32'(err), 32'd0);
    check("w07_run", 32'(dut.run), 32'd2);
`else
    check("w07_step", 32'(step_valid), 32'd0);
    check("w07_err", 32'(err), 32'd1);
    check("w07_err_count", 32'(err_count), 32'd2);
`endif

    // Alternating 2,5: every transition is a jump; err_count saturates at 255
    do_reset();
    for (int i = 0; i < 600; i++) begin
      tick((i % 2 == 0) ? 3'd2 : 3'd5);
      if (i > 0) begin
        check("sat_err", 32'(err), 32'd1);
        check("sat_step", 32'(step_valid), 32'd0);
      end
      if (i == 254) check("sat_cnt_254", 32'(err_count), 32'd254);
      if (i == 255) check("sat_cnt_255", 32'(err_count), 32'd255);
    end
    check("sat_cnt_hold", 32'(err_count), 32'd255);

    // Hold while locked: no pulses, lock retained, next step pulses
    do_reset();
    for (int v = 0; v <= 4; v++) tick(3'(v));
    check("hold_pre_locked", 32'(locked), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick(3'd4);
      check("hold_locked", 32'(locked), 32'd1);
      check("hold_step", 32'(step_valid), 32'd0);
      check("hold_err", 32'(err), 32'd0);
    end
    tick(3'd5);
    check("hold_exit_step", 32'(step_valid), 32'd1);
    check("hold_exit_locked", 32'(locked), 32'd1);

    // Locked with err_count=5, then a one-edge reset
    do_reset();
    tick(3'd5);
    for (int i = 0; i < 5; i++) tick((i % 2 == 0) ? 3'd0 : 3'd5);
    for (int v = 1; v <= 4; v++) tick(3'(v));
    check("pre_rst_err_count", 32'(err_count), 32'd5);
    check("pre_rst_locked", 32'(locked), 32'd1);
    reset = 1'b1;
    tick(3'd4);
    reset = 1'b0;
    check_quiet_outputs("mid_rst");
    check("mid_rst_state", 32'(dut.state), 32'd0);
    check("mid_rst_run", 32'(dut.run), 32'd0);
    check("mid_rst_prev", 32'(dut.prev), 32'd0);
    tick(3'd2);
    check("post_rst_step", 32'(step_valid), 32'd0);
    check("post_rst_err", 32'(err), 32'd0);
    tick(3'd3);
    check("post_rst_first_cmp", 32'(step_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_dir_decoder.md
# count_dir_decoder

Receive-side monitor for a free-running binary up/down counter bus. It samples an incoming WIDTH-bit count every clock and classifies each transition as a step up, a step down, a hold or an illegal jump. It recovers the counter's direction control using the same polarity as the counter's `up_down` input: 1 means counting down. It locks once the count has moved steadily in one direction, and it logs illegal jumps in a saturating error counter for downstream status logic.

## Interface
- `WIDTH`, 3: width of the observed count bus (≥2).
- `LOCK_CNT`, 4: consecutive same-direction legal steps required to assert `locked` (1..15).
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `count_in`  in  WIDTH  observed count, sampled every rising edge.
- `dir`  out  1  recovered direction: 0 = up (+1), 1 = down (−1).
- `step_valid`  out  1  one-cycle pulse for each legal ±1 step.
- `locked`  out  1  direction stable for at least LOCK_CNT steps.
- `err`  out  1  one-cycle pulse on an illegal jump.
- `err_count`  out  8  number of illegal jumps, saturating at 255.

## Operation
- Internal state: `prev` (last sample, WIDTH bits), `run` (4 bits), and a three-state FSM: IDLE, ACQ, LOCK.
- Step classification compares `count_in` with `prev`, using modulo 2^WIDTH arithmetic:
  - `count_in == prev + 1`: UP.
  - `count_in == prev − 1`: DOWN.
  - Equal values: HOLD.
  - Anything else: JUMP.
  - Wrap steps are covered in Configuration.
- IDLE: capture `prev`, go to ACQ with `run=0`. No pulses are issued.
- ACQ:
  - UP/DOWN:
    - Pulse `step_valid` and set `dir`.
    - If this is the first step (`run==0`) or the direction matches `dir`: `run` += 1.
    - If the direction reverses: `run` = 1.
    - When `run` reaches LOCK_CNT, go to LOCK.
  - HOLD: no change.
  - JUMP: pulse `err`, increment `err_count`, set `run=0`, stay in ACQ.
- LOCK:
  - Same-direction step: pulse `step_valid`, stay in LOCK.
  - HOLD: stay in LOCK.
  - Reversal: pulse `step_valid`, update `dir`, go to ACQ with `run=1`, deassert `locked`.
  - JUMP: pulse `err`, increment `err_count`, go to ACQ with `run=0`.
- `prev` is updated on every non-IDLE edge regardless of the classification.
- `err_count` holds at 255 once saturated. Only `reset` clears it.

## Timing
- Reset values:
  - `dir` = 0, `step_valid` = 0, `locked` = 0, `err` = 0, `err_count` = 0.
  - FSM = IDLE, `prev` = 0, `run` = 0.
- All outputs are registered. The classification of the sample taken at edge k against the sample taken at edge k−1 is visible immediately after edge k.
- The first comparison happens at the second edge after reset is released.
- `step_valid` and `err` are single-cycle pulses and are never asserted together.
- `locked` rises immediately after the edge that completes the LOCK_CNT-th consecutive step. It falls immediately after a reversal or a jump.
- Reset asserted mid-operation overrides everything on that edge: all state and outputs return to their reset values, including `err_count`.
- `count_in` must be synchronous to `clk`. No input synchronizer is provided.

## Configuration
- `CNT_DIR_DECODER_WRAP_EN` defined:
  - 2^WIDTH−1 → 0 is classified UP.
  - 0 → 2^WIDTH−1 is classified DOWN.
  - This is for wrapping counters.
- Not defined:
  - Both wrap transitions are classified JUMP.
  - This is for saturating or non-wrapping sources.

## Test plan
All scenarios use WIDTH=3 and LOCK_CNT=4.
- Reset, then `count_in` 0,1,2,3,4 on consecutive edges:
  - `step_valid` pulses on edges 2–5, with `dir=0`.
  - `locked` = 1 after the 5th edge.
  - `err` stays 0.
- Locked counting up, then `count_in` 4,3:
  - `step_valid` pulses, `dir=1`, `locked` falls after that edge.
  - Three further down steps (3→2→1→0) are required to relock.
- `count_in` 6,7,0,1 with the macro defined:
  - Three UP steps and no error.
- Same sequence without the macro:
  - `err` pulses on the 7→0 edge.
  - `err_count` = 1.
  - `run` restarts, so the following 0→1 step gives `run=1`.
- `count_in` 2,5 repeated 300 times:
  - `err` pulses on every transition.
  - `err_count` saturates at 255 and holds there.
  - `step_valid` is never asserted.
- Locked, then `count_in` held at 3 for 10 cycles, then 4:
  - `locked` stays 1 throughout.
  - No pulses during the hold.
  - `step_valid` pulses on the 3→4 step.
- Locked with `err_count` = 5, then `reset` asserted for one edge:
  - Every output returns to its reset value.
  - The FSM is in IDLE.
  - The first sample after reset produces no pulse.
